// File: rtl/pipe_sequencer_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline sequencer (stage metadata, action codes, bubble)
package pipe_ctrl_pkg;
  localparam int RA_W = 5;
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] adr1;
    logic [RA_W-1:0] adr2;
    logic            rs1_used;
    logic            rs2_used;
    logic            regWrite;
    logic            is_load;
  } stage_meta_t;
  typedef enum logic [1:0] {ACT_RUN, ACT_LUSE, ACT_FLUSH, ACT_BUSY} pipe_act_e;
  localparam stage_meta_t BUBBLE = '0;
endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: decode/hazard inputs and enable/valid/metadata outputs of pipe_sequencer
// master: decoder + hazard unit side (drives if_valid, de_*, load_use_haz, flush, mem_busy)
// slave : the sequencer (drives *_we, *_valid, ex_/mem_/wb_ metadata, retire, cnt_*)
interface pipe_sequencer_if #(
  parameter int RA_W  = pipe_ctrl_pkg::RA_W,
  parameter int CNT_W = 32
);
  logic            if_valid;
  logic [RA_W-1:0] de_rd, de_adr1, de_adr2;
  logic            de_regWrite, de_rs1_used, de_rs2_used, de_is_load;
  logic            load_use_haz, flush, mem_busy;
  logic            pc_we, ifde_we, deex_we, exmem_we, memwb_we;
  logic            ifde_valid, ex_valid, mem_valid, wb_valid;
  logic [RA_W-1:0] ex_rd, ex_adr1, ex_adr2, mem_rd, wb_rd;
  logic            ex_rs1_used, ex_rs2_used, ex_is_load, mem_regWrite, wb_regWrite;
  logic            retire;
  logic [CNT_W-1:0] cnt_retired, cnt_stall, cnt_flush;
  modport master (
    output if_valid, de_rd, de_adr1, de_adr2, de_regWrite, de_rs1_used, de_rs2_used, de_is_load,
           load_use_haz, flush, mem_busy,
    input  pc_we, ifde_we, deex_we, exmem_we, memwb_we, ifde_valid, ex_valid, mem_valid, wb_valid,
           ex_rd, ex_adr1, ex_adr2, mem_rd, wb_rd, ex_rs1_used, ex_rs2_used, ex_is_load,
           mem_regWrite, wb_regWrite, retire, cnt_retired, cnt_stall, cnt_flush
  );
  modport slave (
    input  if_valid, de_rd, de_adr1, de_adr2, de_regWrite, de_rs1_used, de_rs2_used, de_is_load,
           load_use_haz, flush, mem_busy,
    output pc_we, ifde_we, deex_we, exmem_we, memwb_we, ifde_valid, ex_valid, mem_valid, wb_valid,
           ex_rd, ex_adr1, ex_adr2, mem_rd, wb_rd, ex_rs1_used, ex_rs2_used, ex_is_load,
           mem_regWrite, wb_regWrite, retire, cnt_retired, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipe_sequencer_perf_counters.sv
// pipe_perf_counters: retired/stall/flush event counters, wrapping modulo 2^CNT_W
// ports: clk, rst_n (sync, active-low), i_retire/i_stall/i_flush event strobes,
//        o_retired/o_stall/o_flush counter values
module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_retire,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_stall,
  output logic [CNT_W-1:0] o_flush
);
  logic [CNT_W-1:0] r_retired, r_stall, r_flush;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
    end else begin
      r_retired <= r_retired + CNT_W'(i_retire);
      r_stall   <= r_stall + CNT_W'(i_stall);
      r_flush   <= r_flush + CNT_W'(i_flush);
    end
  end
  assign o_retired = r_retired;
  assign o_stall   = r_stall;
  assign o_flush   = r_flush;
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline write enables, stage valids and DE->EX->MEM->WB metadata shadow
// ports: CLK, RST_N (sync, active-low), bus (pipe_sequencer_if.slave)
// config: PIPE_PERF_CNT_EN builds the performance counters; otherwise cnt_* read 0
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  pipe_sequencer_if.slave bus
);
  pipe_act_e   w_act;
  stage_meta_t w_de, r_ex, r_mem, r_wb;
  logic        r_ifde_valid, w_back, w_front;
  always_comb w_act = bus.mem_busy ? ACT_BUSY : bus.flush ? ACT_FLUSH : bus.load_use_haz ? ACT_LUSE : ACT_RUN;
  // an empty IF/DE slot enters EX as a clean bubble so downstream metadata is always zero when invalid
  assign w_de = r_ifde_valid ? {1'b1, bus.de_rd, bus.de_adr1, bus.de_adr2, bus.de_rs1_used,
                                bus.de_rs2_used, bus.de_regWrite, bus.de_is_load} : BUBBLE;
  assign w_back  = RST_N && w_act != ACT_BUSY;
  assign w_front = w_back && w_act != ACT_LUSE;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ifde_valid <= 1'b0;
      r_ex         <= BUBBLE;
      r_mem        <= BUBBLE;
      r_wb         <= BUBBLE;
    end else if (w_act != ACT_BUSY) begin
      r_ifde_valid <= w_act == ACT_FLUSH ? 1'b0 : w_act == ACT_LUSE ? r_ifde_valid : bus.if_valid;
      r_ex         <= w_act == ACT_RUN ? w_de : BUBBLE;
      r_mem        <= r_ex;
      r_wb         <= r_mem;
    end
  end
  assign bus.pc_we        = w_front;
  assign bus.ifde_we      = w_front;
  assign bus.deex_we      = w_back;
  assign bus.exmem_we     = w_back;
  assign bus.memwb_we     = w_back;
  assign bus.ifde_valid   = r_ifde_valid;
  assign bus.ex_valid     = r_ex.valid;
  assign bus.mem_valid    = r_mem.valid;
  assign bus.wb_valid     = r_wb.valid;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.ex_adr1      = r_ex.adr1;
  assign bus.ex_adr2      = r_ex.adr2;
  assign bus.ex_rs1_used  = r_ex.valid & r_ex.rs1_used;
  assign bus.ex_rs2_used  = r_ex.valid & r_ex.rs2_used;
  assign bus.ex_is_load   = r_ex.valid & r_ex.is_load;
  assign bus.mem_rd       = r_mem.rd;
  assign bus.wb_rd        = r_wb.rd;
  assign bus.mem_regWrite = r_mem.valid & r_mem.regWrite;
  assign bus.wb_regWrite  = r_wb.valid & r_wb.regWrite;
  assign bus.retire       = RST_N & r_wb.valid & ~bus.mem_busy;
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .i_retire (bus.retire),
    .i_stall  (w_act == ACT_LUSE || w_act == ACT_BUSY),
    .i_flush  (w_act == ACT_FLUSH),
    .o_retired(bus.cnt_retired),
    .o_stall  (bus.cnt_stall),
    .o_flush  (bus.cnt_flush)
  );
`else
  assign bus.cnt_retired = {CNT_W{1'b0}};
  assign bus.cnt_stall   = {CNT_W{1'b0}};
  assign bus.cnt_flush   = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed + randomized checks of pipe_sequencer against an instruction-slot model
module tb_pipe_sequencer;
`ifdef PIPE_PERF_CNT_EN
  localparam int CNT_W = 4;
  localparam int PERF  = 1;
`else
  localparam int CNT_W = 32;
  localparam int PERF  = 0;
`endif
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  pipe_sequencer_if #(.RA_W(5), .CNT_W(CNT_W)) bus ();
  pipe_sequencer #(.CNT_W(CNT_W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    bit v;
    int rd, a1, a2;
    bit u1, u2, rw, ld;
  } inst_t;
  function automatic inst_t nop();
    inst_t t;
    t = '{default: 0};
    return t;
  endfunction
  inst_t m_ex, m_mem, m_wb;
  bit m_ifde;
  logic [CNT_W-1:0] m_ret, m_stall, m_fl;
  always @(posedge CLK) begin
    bit busy, fl, lu;
    inst_t de;
    busy = bus.mem_busy;
    fl = bus.flush && !busy;
    lu = bus.load_use_haz && !busy && !bus.flush;
    if (!RST_N) begin
      m_ifde = 0; m_ex = nop(); m_mem = nop(); m_wb = nop();
      m_ret = '0; m_stall = '0; m_fl = '0;
    end else begin
      if (m_wb.v && !busy) m_ret++;
      if (busy || lu) m_stall++;
      if (fl) m_fl++;
      if (!busy) begin
        de = nop();
        if (m_ifde && !fl && !lu)
          de = '{1, bus.de_rd, bus.de_adr1, bus.de_adr2, bus.de_rs1_used, bus.de_rs2_used,
                 bus.de_regWrite, bus.de_is_load};
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = de;
        if (fl) m_ifde = 0;
        else if (!lu) m_ifde = bus.if_valid;
      end
    end
  end
  always @(negedge CLK) begin
    bit busy, front;
    if (chk_en) begin
      busy = bus.mem_busy;
      front = RST_N && !busy && (bus.flush || !bus.load_use_haz);
      chk("pc_we", bus.pc_we, front);
      chk("ifde_we", bus.ifde_we, front);
      chk("deex_we", bus.deex_we, RST_N && !busy);
      chk("exmem_we", bus.exmem_we, RST_N && !busy);
      chk("memwb_we", bus.memwb_we, RST_N && !busy);
      chk("ifde_valid", bus.ifde_valid, m_ifde);
      chk("ex_valid", bus.ex_valid, m_ex.v);
      chk("mem_valid", bus.mem_valid, m_mem.v);
      chk("wb_valid", bus.wb_valid, m_wb.v);
      chk("ex_rd", bus.ex_rd, m_ex.rd);
      chk("ex_adr1", bus.ex_adr1, m_ex.a1);
      chk("ex_adr2", bus.ex_adr2, m_ex.a2);
      chk("ex_rs1_used", bus.ex_rs1_used, m_ex.v && m_ex.u1);
      chk("ex_rs2_used", bus.ex_rs2_used, m_ex.v && m_ex.u2);
      chk("ex_is_load", bus.ex_is_load, m_ex.v && m_ex.ld);
      chk("mem_rd", bus.mem_rd, m_mem.rd);
      chk("wb_rd", bus.wb_rd, m_wb.rd);
      chk("mem_regWrite", bus.mem_regWrite, m_mem.v && m_mem.rw);
      chk("wb_regWrite", bus.wb_regWrite, m_wb.v && m_wb.rw);
      chk("retire", bus.retire, RST_N && m_wb.v && !busy);
      chk("cnt_retired", bus.cnt_retired, PERF ? m_ret : '0);
      chk("cnt_stall", bus.cnt_stall, PERF ? m_stall : '0);
      chk("cnt_flush", bus.cnt_flush, PERF ? m_fl : '0);
    end
  end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic rnd_de();
    bus.de_rd = 5'($urandom);
    bus.de_adr1 = 5'($urandom);
    bus.de_adr2 = 5'($urandom);
    bus.de_regWrite = 1'($urandom);
    bus.de_rs1_used = 1'($urandom);
    bus.de_rs2_used = 1'($urandom);
    bus.de_is_load = 1'($urandom);
  endtask
  logic [4:0] saved_rd;
  initial begin
    bus.if_valid = 1; bus.load_use_haz = 0; bus.flush = 0; bus.mem_busy = 0;
    rnd_de();
    RST_N = 0;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_ifde_valid", bus.ifde_valid, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_pc_we", bus.pc_we, 0);
    chk("rst_retire", bus.retire, 0);
    chk("rst_cnt_retired", bus.cnt_retired, 0);
    RST_N = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      rnd_de();
      chk("lat_wb_valid", bus.wb_valid, k == 4);
    end
    #2 chk("lat_retire", bus.retire, 1);
    bus.de_is_load = 1; bus.de_rd = 5; bus.de_regWrite = 1;
    cyc();
    rnd_de();
    bus.de_rs1_used = 1; bus.de_adr1 = 5; bus.load_use_haz = 1;
    #2;
    chk("luse_pc_we", bus.pc_we, 0);
    chk("luse_ifde_we", bus.ifde_we, 0);
    chk("luse_deex_we", bus.deex_we, 1);
    cyc();
    bus.load_use_haz = 0;
    chk("luse_ex_valid", bus.ex_valid, 0);
    chk("luse_ex_rs1_used", bus.ex_rs1_used, 0);
    chk("luse_cnt_stall", bus.cnt_stall, PERF ? 1 : 0);
    cyc();
    chk("dep_ex_adr1", bus.ex_adr1, 5);
    chk("dep_ex_rs1_used", bus.ex_rs1_used, 1);
    bus.de_rd = 7; bus.de_regWrite = 1;
    cyc();
    rnd_de();
    bus.flush = 1;
    #2 chk("flush_pc_we", bus.pc_we, 1);
    cyc();
    bus.flush = 0;
    chk("flush_ifde_valid", bus.ifde_valid, 0);
    chk("flush_ex_valid", bus.ex_valid, 0);
    chk("flush_mem_rd", bus.mem_rd, 7);
    chk("flush_mem_regWrite", bus.mem_regWrite, 1);
    chk("flush_cnt_flush", bus.cnt_flush, PERF ? 1 : 0);
    bus.flush = 1; bus.load_use_haz = 1;
    #2 chk("sim_pc_we", bus.pc_we, 1);
    cyc();
    bus.flush = 0; bus.load_use_haz = 0;
    chk("sim_ifde_valid", bus.ifde_valid, 0);
    chk("sim_cnt_stall", bus.cnt_stall, PERF ? 1 : 0);
    chk("sim_cnt_flush", bus.cnt_flush, PERF ? 2 : 0);
    repeat (4) begin
      cyc();
      rnd_de();
    end
    chk("pre_busy_wb_valid", bus.wb_valid, 1);
    saved_rd = bus.wb_rd;
    bus.mem_busy = 1;
    repeat (3) begin
      #2;
      chk("busy_retire", bus.retire, 0);
      chk("busy_memwb_we", bus.memwb_we, 0);
      cyc();
    end
    chk("busy_wb_rd", bus.wb_rd, saved_rd);
    chk("busy_wb_valid", bus.wb_valid, 1);
    bus.mem_busy = 0;
    #2;
    chk("busy_drop_retire", bus.retire, 1);
    chk("busy_cnt_stall", bus.cnt_stall, PERF ? 4 : 0);
    cyc();
    repeat (3000) begin
      RST_N = $urandom_range(0, 49) != 0;
      bus.if_valid = $urandom_range(0, 9) < 8;
      bus.mem_busy = $urandom_range(0, 99) < 15;
      bus.flush = $urandom_range(0, 99) < 10;
      bus.load_use_haz = $urandom_range(0, 99) < 15;
      rnd_de();
      cyc();
    end
    RST_N = 0; bus.if_valid = 1; bus.mem_busy = 0; bus.flush = 0; bus.load_use_haz = 0;
    cyc();
    cyc();
    RST_N = 1;
    repeat (21) begin
      cyc();
      rnd_de();
    end
    chk("wrap_cnt_retired", bus.cnt_retired, PERF ? 1 : 0);
    @(negedge CLK);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
